// File: rtl/nec_ir_decoder.sv
// NEC infrared remote decoder.
// Synchronises the demodulated receiver line, measures each mark/space width in
// microseconds and walks the NEC frame structure (leader, 32 data bits, stop mark,
// or the short repeat frame). Good data frames update ir_out; every malformed,
// out-of-window or timed-out frame produces a single error pulse.
module nec_ir_decoder #(
  parameter int unsigned CYCLES_PER_US = 74,
  parameter int unsigned TIMEOUT_US    = 12000,
  parameter bit          CHECK_CMD     = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic        ir_rx_in,
  output logic [31:0] ir_out,
  output logic        valid_out,
  output logic        repeat_out,
  output logic        error_out,
  output logic        busy_out
);

  localparam int unsigned PreW = (CYCLES_PER_US > 1) ? $clog2(CYCLES_PER_US) : 1;
  localparam logic [PreW-1:0] PreMax = PreW'(CYCLES_PER_US - 1);

  localparam logic [13:0] WidthMax = 14'h3FFF;
  localparam logic [13:0] Timeout  = 14'(TIMEOUT_US);

  // Width windows in microseconds, both ends inclusive.
  localparam logic [13:0] LeadMarkMin = 14'd8000;
  localparam logic [13:0] LeadMarkMax = 14'd10000;
  localparam logic [13:0] LeadDataMin = 14'd4000;
  localparam logic [13:0] LeadDataMax = 14'd5000;
  localparam logic [13:0] LeadRptMin  = 14'd2000;
  localparam logic [13:0] LeadRptMax  = 14'd2500;
  localparam logic [13:0] BitMarkMin  = 14'd400;
  localparam logic [13:0] BitMarkMax  = 14'd750;
  localparam logic [13:0] Space0Min   = 14'd400;
  localparam logic [13:0] Space0Max   = 14'd750;
  localparam logic [13:0] Space1Min   = 14'd1400;
  localparam logic [13:0] Space1Max   = 14'd1900;

  typedef enum logic [2:0] {
    StIdle,
    StLeadMark,
    StLeadSpace,
    StBitMark,
    StBitSpace,
    StStopMark,
    StRepeatStop
  } state_e;

  function automatic logic in_win(input logic [13:0] w, input logic [13:0] lo,
                                  input logic [13:0] hi);
    return (w >= lo) && (w <= hi);
  endfunction

  // Input path
  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  // Timing
  logic [PreW-1:0] pre_q, pre_d;
  logic [13:0]     width_q, width_d;

  // Frame state and datapath
  state_e      state_q, state_d;
  logic [31:0] shreg_q, shreg_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [31:0] ir_q, ir_d;
  logic        have_frame_q, have_frame_d;
  logic        valid_q, valid_d;
  logic        repeat_q, repeat_d;
  logic        error_q, error_d;
  logic        busy_q, busy_d;

  // Decoded conditions
  logic edge_det, fall, rise, tick;
  logic lead_mark_win, lead_data_win, lead_rpt_win;
  logic bit_mark_win, space0_win, space1_win;
  logic edge_ok, bad_edge, timeout_hit, last_bit, cmd_ok;

  assign edge_det = sync2_q ^ prev_q;
  assign fall     = edge_det & ~sync2_q;
  assign rise     = edge_det & sync2_q;
  assign tick     = (pre_q == PreMax);

  assign lead_mark_win = in_win(width_q, LeadMarkMin, LeadMarkMax);
  assign lead_data_win = in_win(width_q, LeadDataMin, LeadDataMax);
  assign lead_rpt_win  = in_win(width_q, LeadRptMin, LeadRptMax);
  assign bit_mark_win  = in_win(width_q, BitMarkMin, BitMarkMax);
  assign space0_win    = in_win(width_q, Space0Min, Space0Max);
  assign space1_win    = in_win(width_q, Space1Min, Space1Max);

  assign last_bit = (bit_cnt_q == 6'd31);
  assign cmd_ok   = (shreg_q[15:8] == ~shreg_q[7:0]);

  // Input synchroniser followed by the edge-detect register
  always_comb begin
    sync1_d = ir_rx_in;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  // Free-running microsecond prescaler and saturating width counter
  always_comb begin
    pre_d   = tick ? '0 : pre_q + 1'b1;
    width_d = width_q;
    if (edge_det) begin
      width_d = '0;
    end else if (tick && (width_q != WidthMax)) begin
      width_d = width_q + 14'd1;
    end
  end

  // Does the current edge have the expected direction and a width inside its window
  always_comb begin
    edge_ok = 1'b0;
    unique case (state_q)
      StIdle:                              edge_ok = 1'b0;
      StLeadMark:                          edge_ok = rise && lead_mark_win;
      StLeadSpace:                         edge_ok = fall && (lead_data_win || lead_rpt_win);
      StBitMark, StStopMark, StRepeatStop: edge_ok = rise && bit_mark_win;
      StBitSpace:                          edge_ok = fall && (space0_win || space1_win);
      default:                             edge_ok = 1'b0;
    endcase
  end

  assign bad_edge    = edge_det && (state_q != StIdle) && !edge_ok;
  assign timeout_hit = !edge_det && (state_q != StIdle) && (width_q == Timeout);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (state_q == StIdle) begin
      if (fall) state_d = StLeadMark;
    end else if (bad_edge) begin
      // A malformed edge that starts a mark may be the leader of a fresh frame.
      state_d = fall ? StLeadMark : StIdle;
    end else if (timeout_hit) begin
      state_d = StIdle;
    end else if (edge_ok) begin
      unique case (state_q)
        StLeadMark:   state_d = StLeadSpace;
        StLeadSpace:  state_d = lead_data_win ? StBitMark : StRepeatStop;
        StBitMark:    state_d = StBitSpace;
        StBitSpace:   state_d = last_bit ? StStopMark : StBitMark;
        StStopMark:   state_d = StIdle;
        StRepeatStop: state_d = StIdle;
        default:      state_d = StIdle;
      endcase
    end
  end

  // Datapath updates and registered output pulses
  always_comb begin
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    ir_d         = ir_q;
    have_frame_d = have_frame_q;
    valid_d      = 1'b0;
    repeat_d     = 1'b0;
    error_d      = 1'b0;
    if (bad_edge || timeout_hit) begin
      error_d = 1'b1;
    end else if (edge_ok) begin
      unique case (state_q)
        StLeadSpace: bit_cnt_d = '0;
        StBitSpace: begin
          shreg_d   = {shreg_q[30:0], space1_win};
          bit_cnt_d = bit_cnt_q + 6'd1;
        end
        StStopMark: begin
          if (!CHECK_CMD || cmd_ok) begin
            ir_d         = shreg_q;
            valid_d      = 1'b1;
            have_frame_d = 1'b1;
          end else begin
            error_d = 1'b1;
          end
        end
        // A repeat with no earlier good frame has nothing to repeat and is dropped.
        StRepeatStop: repeat_d = have_frame_q;
        default: ;
      endcase
    end
    busy_d = (state_d != StIdle);
  end

  // Input path registers; reset to the idle (high) line level
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  // Timing registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pre_q   <= '0;
      width_q <= '0;
    end else begin
      pre_q   <= pre_d;
      width_q <= width_d;
    end
  end

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      ir_q         <= '0;
      have_frame_q <= 1'b0;
      valid_q      <= 1'b0;
      repeat_q     <= 1'b0;
      error_q      <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      ir_q         <= ir_d;
      have_frame_q <= have_frame_d;
      valid_q      <= valid_d;
      repeat_q     <= repeat_d;
      error_q      <= error_d;
      busy_q       <= busy_d;
    end
  end

  assign ir_out     = ir_q;
  assign valid_out  = valid_q;
  assign repeat_out = repeat_q;
  assign error_out  = error_q;
  assign busy_out   = busy_q;

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Bench for nec_ir_decoder. Two decoders share one IR line: index 0 checks the
// command checksum, index 1 does not. Stimulus is a directed sequence of frames;
// an event-level model posts the pulse each frame must produce and the cycle it
// is due, and one compare process checks pulses and ir_out on every cycle.
module tb_nec_ir_decoder;

  localparam int unsigned Cpu = 4;
  localparam int unsigned Gap = 2000;
  localparam logic [2:0] KValid  = 3'b100;
  localparam logic [2:0] KRepeat = 3'b010;
  localparam logic [2:0] KError  = 3'b001;

  typedef struct {
    logic [2:0]  kind;
    int          lo;
    int          hi;
    logic [31:0] code;
  } ev_t;

  logic        clk     = 1'b0;
  logic        rst_n   = 1'b0;
  logic        ir_line = 1'b1;
  logic [31:0] ir_o     [2];
  logic        valid_o  [2];
  logic        repeat_o [2];
  logic        error_o  [2];
  logic        busy_o   [2];

  int cyc      = 0;
  int edge_cyc = 0;
  int checks   = 0;
  int errors   = 0;

  ev_t         exp_q [2][$];
  logic [31:0] exp_ir [2];
  bit          have_frame [2];
  bit          chk_cmd [2];

  nec_ir_decoder #(
    .CYCLES_PER_US(Cpu),
    .TIMEOUT_US   (12000),
    .CHECK_CMD    (1'b1)
  ) u_dut_chk (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .ir_rx_in  (ir_line),
    .ir_out    (ir_o[0]),
    .valid_out (valid_o[0]),
    .repeat_out(repeat_o[0]),
    .error_out (error_o[0]),
    .busy_out  (busy_o[0])
  );

  nec_ir_decoder #(
    .CYCLES_PER_US(Cpu),
    .TIMEOUT_US   (12000),
    .CHECK_CMD    (1'b0)
  ) u_dut_nochk (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .ir_rx_in  (ir_line),
    .ir_out    (ir_o[1]),
    .valid_out (valid_o[1]),
    .repeat_out(repeat_o[1]),
    .error_out (error_o[1]),
    .busy_out  (busy_o[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- model ----------------
  function automatic bit cmd_ok(input logic [31:0] c);
    return c[15:8] == ~c[7:0];
  endfunction

  task automatic post(input int i, input logic [2:0] kind, input int lo, input int hi,
                      input logic [31:0] code);
    ev_t e;
    e.kind = kind;
    e.lo   = lo;
    e.hi   = hi;
    e.code = code;
    exp_q[i].push_back(e);
  endtask

  task automatic post_error_all();
    for (int i = 0; i < 2; i++) post(i, KError, edge_cyc + 3, edge_cyc + 3, 32'h0);
  endtask

  task automatic post_frame_end(input logic [31:0] code);
    for (int i = 0; i < 2; i++) begin
      if (!chk_cmd[i] || cmd_ok(code)) begin
        post(i, KValid, edge_cyc + 3, edge_cyc + 3, code);
        have_frame[i] = 1'b1;
      end else begin
        post(i, KError, edge_cyc + 3, edge_cyc + 3, 32'h0);
      end
    end
  endtask

  task automatic post_repeat();
    for (int i = 0; i < 2; i++)
      if (have_frame[i]) post(i, KRepeat, edge_cyc + 3, edge_cyc + 3, 32'h0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      exp_q[i].delete();
      exp_ir[i]     = 32'h0;
      have_frame[i] = 1'b0;
    end
  endtask

  // ---------------- compare ----------------
  task automatic check_dut(input int i);
    logic [2:0] got;
    got = {valid_o[i], repeat_o[i], error_o[i]};
    while (exp_q[i].size() > 0 && exp_q[i][0].hi < cyc) begin
      checks++;
      errors++;
      $display("FAIL missed_pulse dut%0d cyc %0d got none want kind %b due by cyc %0d",
               i, cyc, exp_q[i][0].kind, exp_q[i][0].hi);
      void'(exp_q[i].pop_front());
    end
    if (got != 3'b000) begin
      checks++;
      if (exp_q[i].size() > 0 && exp_q[i][0].lo <= cyc && exp_q[i][0].kind == got) begin
        if (got == KValid) exp_ir[i] = exp_q[i][0].code;
        void'(exp_q[i].pop_front());
      end else begin
        errors++;
        $display("FAIL unexpected_pulse dut%0d cyc %0d got {valid,repeat,error}=%b want none",
                 i, cyc, got);
      end
    end
    checks++;
    if (ir_o[i] !== exp_ir[i]) begin
      errors++;
      $display("FAIL ir_out dut%0d cyc %0d got %h want %h", i, cyc, ir_o[i], exp_ir[i]);
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        checks++;
        if ({valid_o[i], repeat_o[i], error_o[i], busy_o[i]} !== 4'b0000 ||
            ir_o[i] !== 32'h0) begin
          errors++;
          $display("FAIL reset_outputs dut%0d cyc %0d got ir %h v%b r%b e%b b%b want all 0",
                   i, cyc, ir_o[i], valid_o[i], repeat_o[i], error_o[i], busy_o[i]);
        end
      end else begin
        check_dut(i);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic expect_eq(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic drive(input logic lvl);
    ir_line  = lvl;
    edge_cyc = cyc;
  endtask

  task automatic hold(input int us);
    repeat (us * Cpu) @(negedge clk);
  endtask

  // Full NEC data frame; rst_bit >= 0 pulses reset low during that bit's mark and
  // leaves it low for the rest of the frame.
  task automatic send_frame(input logic [31:0] code, input bit err_at_start, input int rst_bit);
    drive(1'b0);
    if (err_at_start) post_error_all();
    hold(9000);
    drive(1'b1);
    hold(4500);
    for (int b = 31; b >= 0; b--) begin
      drive(1'b0);
      if (31 - b == rst_bit) begin
        hold(200);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        for (int i = 0; i < 2; i++) begin
          expect_eq("async_reset_ir", ir_o[i], 32'h0);
          expect_eq("async_reset_busy", {31'h0, busy_o[i]}, 32'h0);
        end
        hold(360);
      end else begin
        hold(560);
      end
      drive(1'b1);
      hold(code[b] ? 1690 : 560);
    end
    drive(1'b0);
    hold(560);
    drive(1'b1);
    if (rst_bit < 0) post_frame_end(code);
    hold(Gap);
  endtask

  task automatic send_repeat();
    drive(1'b0);
    hold(9000);
    drive(1'b1);
    hold(2250);
    drive(1'b0);
    hold(560);
    drive(1'b1);
    post_repeat();
    hold(Gap);
  endtask

  initial begin
    logic [31:0] code;
    chk_cmd[0] = 1'b1;
    chk_cmd[1] = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      expect_eq("reset_ir", ir_o[i], 32'h0);
      expect_eq("reset_pulses", {29'h0, valid_o[i], repeat_o[i], error_o[i]}, 32'h0);
      expect_eq("reset_busy", {31'h0, busy_o[i]}, 32'h0);
    end
    #2 rst_n = 1'b1;
    hold(500);

    // Repeat straight after reset: nothing to repeat
    send_repeat();
    expect_eq("repeat_after_reset_ir", ir_o[0], 32'h0);

    // Good frame, then repeat
    send_frame(32'h20DF_5BA4, 1'b0, -1);
    expect_eq("frame1_ir", ir_o[0], 32'h20DF_5BA4);
    expect_eq("frame1_busy", {31'h0, busy_o[0]}, 32'h0);
    send_repeat();
    expect_eq("repeat_ir_held", ir_o[0], 32'h20DF_5BA4);

    // Bad checksum: rejected with checking, accepted without
    send_frame(32'h20DF_5BA5, 1'b0, -1);
    expect_eq("badsum_ir_chk", ir_o[0], 32'h20DF_5BA4);
    expect_eq("badsum_ir_nochk", ir_o[1], 32'h20DF_5BA5);

    // Short leader mark
    drive(1'b0);
    hold(7000);
    drive(1'b1);
    post_error_all();
    hold(Gap);

    // Bit 10 space of 1100 us; the mark that ends it is the leader of a good frame
    code = 32'h20DF_5BA4;
    drive(1'b0);
    hold(9000);
    drive(1'b1);
    hold(4500);
    for (int b = 31; b >= 22; b--) begin
      drive(1'b0);
      hold(560);
      drive(1'b1);
      hold(code[b] ? 1690 : 560);
    end
    drive(1'b0);
    hold(560);
    drive(1'b1);
    hold(1100);
    send_frame(32'h20DF_5AA5, 1'b1, -1);
    expect_eq("resync_ir", ir_o[0], 32'h20DF_5AA5);

    // Line held high after bit 5 mark: one timeout error
    drive(1'b0);
    hold(9000);
    drive(1'b1);
    hold(4500);
    for (int b = 31; b >= 27; b--) begin
      drive(1'b0);
      hold(560);
      drive(1'b1);
      hold(code[b] ? 1690 : 560);
    end
    drive(1'b0);
    hold(560);
    expect_eq("midframe_busy", {31'h0, busy_o[0]}, 32'h1);
    drive(1'b1);
    for (int i = 0; i < 2; i++) post(i, KError, edge_cyc + 48000, edge_cyc + 48005, 32'h0);
    hold(13000);
    for (int i = 0; i < 2; i++) expect_eq("timeout_busy", {31'h0, busy_o[i]}, 32'h0);

    // Reset during bit 20, released once the line is idle again
    send_frame(32'h20DF_5BA4, 1'b0, 20);
    #2 rst_n = 1'b1;
    hold(1000);
    expect_eq("post_reset_ir", ir_o[0], 32'h0);
    send_frame(32'h00FF_807F, 1'b0, -1);
    expect_eq("post_reset_frame_ir", ir_o[0], 32'h00FF_807F);

    hold(500);
    for (int i = 0; i < 2; i++) expect_eq("pending_events", exp_q[i].size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
